hw_qsys_cpu_cpu_mult_combine: RTL and testbench
===============================================

// Module: hw_qsys_cpu_cpu_mult_combine
// PURPOSE
//  Consumer stage directly downstream of the CPU 16x16 multiplier cell. Takes its three
//  registered partial products (M_mul_cell_p1/p2/p3) and forms the low 32 bits of the
//  32x32 product. Carries the product into the A stage with stall and flush control.
//  Flags read-after-write hazards so E-stage instructions wait for an in-flight product.
// PARAMETERS
//  DATA_W    32  operand/result width; only 32 is supported
//  HALF_W    16  partial-product operand width, equal to DATA_W/2
//  REGNUM_W  5   destination/source register-number width
// PORTS
//  clk                 in   1         system clock
//  reset_n             in   1         asynchronous active-low reset
//  E_mul_valid         in   1         E-stage multiply issues this cycle (cell sees E_src1/2)
//  E_dst_regnum        in   REGNUM_W  destination register of issuing multiply
//  E_src_regnum_a      in   REGNUM_W  rA of the instruction currently in E
//  E_src_regnum_b      in   REGNUM_W  rB of the instruction currently in E
//  M_en                in   1         M advance; same signal drives the cell's ena0
//  M_kill              in   1         flush of the M-stage instruction
//  A_en                in   1         A advance / writeback accept
//  M_mul_cell_p1       in   DATA_W    src1[15:0]*src2[15:0]
//  M_mul_cell_p2       in   DATA_W    src1[15:0]*src2[31:16]
//  M_mul_cell_p3       in   DATA_W    src1[31:16]*src2[15:0]
//  A_mul_valid         out  1         A_mul_result holds a live product
//  A_mul_result        out  DATA_W    low 32 bits of src1*src2
//  A_mul_dst_regnum    out  REGNUM_W  destination register for A_mul_result
//  E_mul_hazard        out  1         E instruction reads a register with a product in flight
// BEHAVIOUR
//  - Reset: every register and output is 0 (A_mul_valid, A_mul_result, A_mul_dst_regnum,
//    E_mul_hazard, and the internal M_valid/M_dst).
//  - Capture: on M_en, M_valid<=E_mul_valid and M_dst<=E_dst_regnum. The cell registers
//    its products on the same edge, so p1..p3 are aligned with M_valid.
//  - Combine, combinational in M: sum = p1 + {p2[15:0]+p3[15:0], 16'h0} mod 2^32.
//    p2[31:16] and p3[31:16] are ignored. The result is sign-agnostic (low word only).
//  - A capture: on A_en, A_mul_valid<=M_valid&~M_kill, A_mul_result<=sum,
//    A_mul_dst_regnum<=M_dst. Without A_en all A registers hold.
//  - Latency: one M_en advance plus one A_en advance from issue to A_mul_valid.
//  - Stall: M_en=0 holds M_valid and M_dst; the cell holds p1..p3, so the product stays stable.
//  - Kill: M_kill=1 clears M_valid on the next edge, regardless of M_en. Kill together with
//    A_en: kill wins and no A_mul_valid is produced. Kill never affects the A stage.
//  - Simultaneous M_en and A_en: the M entry moves to A while the new issue enters M.
//  - Hazard: E_mul_hazard=1 when, for either stage X in {M, A}, X_valid and X_dst!=0 and
//    X_dst equals E_src_regnum_a or E_src_regnum_b. It is combinational.
//  - r0 destination: the product still flows through, but it never raises a hazard.
//  - A mid-operation reset discards all in-flight products immediately.
// CONFIGURATION
//  HW_QSYS_MUL_SPLIT_ADD_EN
//   - Defined: the add is split across two stages.
//     - M stage: registers mid17 = p2[15:0]+p3[15:0] (17 bits, carry dropped when used)
//       and p1 into an internal stage P, advanced by A_en.
//     - A stage: computes p1 + {mid17[15:0], 16'h0}.
//     - Issue-to-result latency grows by one A_en advance.
//     - P_valid/P_dst join the hazard check.
//     - M_kill clears only M. P follows the same kill/hold rules as A.
//   - Undefined: single-stage combine exactly as described above.
// STRUCTURE
//  - Shared package hw_qsys_cpu_mul_pkg holds:
//    - constants MUL_DATA_W=32, MUL_HALF_W=16, MUL_REGNUM_W=5;
//    - typedef mul_stage_t {logic valid; logic [4:0] dst;}.
//  - Sub-module hw_qsys_cpu_mul_hazard_cmp: one instance per tracked stage. It compares one
//    stage's valid/dst against both E source registers. The top level ORs the instance outputs.
// TESTING
//  1. src1=0x0001_0002, src2=0x0003_0004 (p1=8, p2=6, p3=4), M_en=A_en=1
//     -> A_mul_result=0x000A_0008 and A_mul_valid=1 two edges after issue.
//  2. src1=src2=0xFFFF_FFFF (p1=p2=p3=0xFFFE_0001) -> A_mul_result=0x0000_0001 (wrap check).
//  3. Issue, then M_en=0 for 3 cycles with p1..p3 held -> A_mul_valid stays 0.
//     Release -> result appears intact.
//  4. Issue dst=7, then M_kill=1 with A_en=1 on the next cycle -> A_mul_valid=0, A registers
//     keep their data; the following issue completes normally.
//  5. M holds dst=9 valid, E_src_regnum_b=9 -> E_mul_hazard=1.
//     Same with dst=0 -> E_mul_hazard=0. After A retires dst=9 -> 0.
//  6. Assert reset_n=0 mid-flight with M and A both valid -> all outputs 0 asynchronously.
//     Run test 1 with HW_QSYS_MUL_SPLIT_ADD_EN defined -> same value, one advance later.

Source files
------------

// File: rtl/hw_qsys_cpu_mul_pkg.sv
// Shared types and constants for the CPU multiplier combine path.
package hw_qsys_cpu_mul_pkg;

    localparam int MUL_DATA_W   = 32;
    localparam int MUL_HALF_W   = 16;
    localparam int MUL_REGNUM_W = 5;

    // Occupancy of one pipeline stage that carries a product.
    typedef struct packed {
        logic                    valid;
        logic [MUL_REGNUM_W-1:0] dst;
    } mul_stage_t;

    // Low word of the 32x32 product from the three 16x16 partial products.
    // The cross terms only reach the upper half, so their own upper halves drop out.
    function automatic logic [MUL_DATA_W-1:0] mul_combine(
        input logic [MUL_DATA_W-1:0] p1,
        input logic [MUL_DATA_W-1:0] p2,
        input logic [MUL_DATA_W-1:0] p3
    );
        logic [MUL_HALF_W-1:0] mid;
        mid = p2[MUL_HALF_W-1:0] + p3[MUL_HALF_W-1:0];
        return p1 + {mid, {MUL_HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/hw_qsys_cpu_mul_hazard_cmp.sv
// Read-after-write check of one in-flight product stage against both E sources.
// Register 0 is never a real destination, so it never raises a hazard.
module hw_qsys_cpu_mul_hazard_cmp
    import hw_qsys_cpu_mul_pkg::*;
(
    input  mul_stage_t              stage,
    input  logic [MUL_REGNUM_W-1:0] src_a,
    input  logic [MUL_REGNUM_W-1:0] src_b,
    output logic                    hit
);

    // Live, non-r0 destination that matches either source register.
    always_comb begin
        hit = stage.valid && (stage.dst != '0) &&
              ((stage.dst == src_a) || (stage.dst == src_b));
    end

endmodule

// File: rtl/hw_qsys_cpu_cpu_mult_combine.sv
// Combines the multiplier cell's partial products into the low 32-bit product and
// carries it from M into A with stall/flush control, flagging E-stage RAW hazards.
// Build option HW_QSYS_MUL_SPLIT_ADD_EN: splits the add over an extra stage P.
module hw_qsys_cpu_cpu_mult_combine
    import hw_qsys_cpu_mul_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int HALF_W   = 16,
    parameter int REGNUM_W = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                E_mul_valid,
    input  logic [REGNUM_W-1:0] E_dst_regnum,
    input  logic [REGNUM_W-1:0] E_src_regnum_a,
    input  logic [REGNUM_W-1:0] E_src_regnum_b,
    input  logic                M_en,
    input  logic                M_kill,
    input  logic                A_en,
    input  logic [DATA_W-1:0]   M_mul_cell_p1,
    input  logic [DATA_W-1:0]   M_mul_cell_p2,
    input  logic [DATA_W-1:0]   M_mul_cell_p3,
    output logic                A_mul_valid,
    output logic [DATA_W-1:0]   A_mul_result,
    output logic [REGNUM_W-1:0] A_mul_dst_regnum,
    output logic                E_mul_hazard
);

`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
    localparam int NSTAGE = 3;
`else
    localparam int NSTAGE = 2;
`endif

    logic                m_valid_q, m_valid_d;
    logic [REGNUM_W-1:0] m_dst_q, m_dst_d;
    logic                a_valid_q, a_valid_d;
    logic [DATA_W-1:0]   a_result_q, a_result_d;
    logic [REGNUM_W-1:0] a_dst_q, a_dst_d;

`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
    logic                p_valid_q, p_valid_d;
    logic [REGNUM_W-1:0] p_dst_q, p_dst_d;
    logic [DATA_W-1:0]   p_lo_q, p_lo_d;
    logic [HALF_W:0]     p_mid_q, p_mid_d;
    // The carry out of the mid sum lands above bit 31 and is discarded.
    logic                unused_split;
    assign unused_split = p_mid_q[HALF_W];
`endif

    // Upper halves of the cross products only affect bits above the low word.
    logic unused_cell_hi;
    assign unused_cell_hi = ^{M_mul_cell_p2[DATA_W-1:HALF_W], M_mul_cell_p3[DATA_W-1:HALF_W]};

    // M stage: kill clears the entry regardless of advance; stall holds it.
    always_comb begin
        m_valid_d = M_en ? E_mul_valid : m_valid_q;
        if (M_kill) begin
            m_valid_d = 1'b0;
        end
        m_dst_d = M_en ? E_dst_regnum : m_dst_q;
    end

`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
    // P stage holds p1 and the mid sum; A finishes the add. Both advance on A_en.
    always_comb begin
        p_valid_d  = p_valid_q;
        p_dst_d    = p_dst_q;
        p_lo_d     = p_lo_q;
        p_mid_d    = p_mid_q;
        a_valid_d  = a_valid_q;
        a_result_d = a_result_q;
        a_dst_d    = a_dst_q;
        if (A_en) begin
            p_valid_d  = m_valid_q & ~M_kill;
            p_dst_d    = m_dst_q;
            p_lo_d     = M_mul_cell_p1;
            p_mid_d    = {1'b0, M_mul_cell_p2[HALF_W-1:0]} + {1'b0, M_mul_cell_p3[HALF_W-1:0]};
            a_valid_d  = p_valid_q;
            a_result_d = p_lo_q + {p_mid_q[HALF_W-1:0], {HALF_W{1'b0}}};
            a_dst_d    = p_dst_q;
        end
    end
`else
    // A stage captures the single-cycle combined sum; kill stops the valid bit only.
    always_comb begin
        a_valid_d  = a_valid_q;
        a_result_d = a_result_q;
        a_dst_d    = a_dst_q;
        if (A_en) begin
            a_valid_d  = m_valid_q & ~M_kill;
            a_result_d = mul_combine(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
            a_dst_d    = m_dst_q;
        end
    end
`endif

    // Pipeline registers; reset discards every in-flight product at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q  <= 1'b0;
            m_dst_q    <= '0;
            a_valid_q  <= 1'b0;
            a_result_q <= '0;
            a_dst_q    <= '0;
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
            p_valid_q  <= 1'b0;
            p_dst_q    <= '0;
            p_lo_q     <= '0;
            p_mid_q    <= '0;
`endif
        end else begin
            m_valid_q  <= m_valid_d;
            m_dst_q    <= m_dst_d;
            a_valid_q  <= a_valid_d;
            a_result_q <= a_result_d;
            a_dst_q    <= a_dst_d;
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
            p_valid_q  <= p_valid_d;
            p_dst_q    <= p_dst_d;
            p_lo_q     <= p_lo_d;
            p_mid_q    <= p_mid_d;
`endif
        end
    end

    assign A_mul_valid      = a_valid_q;
    assign A_mul_result     = a_result_q;
    assign A_mul_dst_regnum = a_dst_q;

    // One comparator per stage that can hold a product not yet written back.
    mul_stage_t       stages [NSTAGE];
    logic [NSTAGE-1:0] stage_hit;

    assign stages[0] = '{valid: m_valid_q, dst: m_dst_q};
    assign stages[1] = '{valid: a_valid_q, dst: a_dst_q};
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
    assign stages[2] = '{valid: p_valid_q, dst: p_dst_q};
`endif

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_hz
            hw_qsys_cpu_mul_hazard_cmp u_cmp (
                .stage (stages[gi]),
                .src_a (E_src_regnum_a),
                .src_b (E_src_regnum_b),
                .hit   (stage_hit[gi])
            );
        end
    endgenerate

    assign E_mul_hazard = |stage_hit;

endmodule

// File: tb/tb_hw_qsys_cpu_cpu_mult_combine.sv
// Bench for hw_qsys_cpu_cpu_mult_combine: stands in for the multiplier cell, runs a
// hand-computed vector table, reset and latency sequences, then random traffic
// checked against a transaction-level model of the product pipeline.
module tb_hw_qsys_cpu_cpu_mult_combine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        E_mul_valid;
    logic [4:0]  E_dst_regnum, E_src_regnum_a, E_src_regnum_b;
    logic        M_en, M_kill, A_en;
    logic [31:0] src1, src2;
    logic [31:0] c_p1, c_p2, c_p3;
    logic        A_mul_valid;
    logic [31:0] A_mul_result;
    logic [4:0]  A_mul_dst_regnum;
    logic        E_mul_hazard;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hw_qsys_cpu_cpu_mult_combine dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .E_mul_valid      (E_mul_valid),
        .E_dst_regnum     (E_dst_regnum),
        .E_src_regnum_a   (E_src_regnum_a),
        .E_src_regnum_b   (E_src_regnum_b),
        .M_en             (M_en),
        .M_kill           (M_kill),
        .A_en             (A_en),
        .M_mul_cell_p1    (c_p1),
        .M_mul_cell_p2    (c_p2),
        .M_mul_cell_p3    (c_p3),
        .A_mul_valid      (A_mul_valid),
        .A_mul_result     (A_mul_result),
        .A_mul_dst_regnum (A_mul_dst_regnum),
        .E_mul_hazard     (E_mul_hazard)
    );

    // Multiplier cell stand-in: registers its partial products when M advances.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_p1 <= '0; c_p2 <= '0; c_p3 <= '0;
        end else if (M_en) begin
            c_p1 <= {16'h0, src1[15:0]}  * {16'h0, src2[15:0]};
            c_p2 <= {16'h0, src1[15:0]}  * {16'h0, src2[31:16]};
            c_p3 <= {16'h0, src1[31:16]} * {16'h0, src2[15:0]};
        end
    end

    // Reference model: each stage holds {valid, dst, full low-word product}.
    logic        mv, pv, av;
    logic [4:0]  mdst, pdst, adst;
    logic [31:0] mprod, pprod, ares;

    task automatic model_reset();
        mv = 0; pv = 0; av = 0; mdst = 0; pdst = 0; adst = 0;
        mprod = 0; pprod = 0; ares = 0;
    endtask

    function automatic logic hit(input logic v, input logic [4:0] d,
                                 input logic [4:0] a, input logic [4:0] b);
        return v && (d != 0) && (d == a || d == b);
    endfunction

    task automatic model_step(input logic ev, input logic [4:0] edst, input logic men,
                              input logic kill, input logic aen,
                              input logic [31:0] s1, input logic [31:0] s2);
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
        if (aen) begin
            av = pv; ares = pprod; adst = pdst;
            pv = mv & ~kill; pprod = mprod; pdst = mdst;
        end
`else
        if (aen) begin
            av = mv & ~kill; ares = mprod; adst = mdst;
        end
`endif
        if (men) begin
            mv = ev; mdst = edst; mprod = s1 * s2;
        end
        if (kill) mv = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive inputs at the negedge, sample hazard, clock, sample A outputs.
    task automatic cycle(input logic ev, input logic [4:0] edst, input logic [4:0] sa,
                         input logic [4:0] sb, input logic men, input logic kill,
                         input logic aen, input logic [31:0] s1, input logic [31:0] s2,
                         output logic hz, output logic mhz);
        E_mul_valid = ev; E_dst_regnum = edst; E_src_regnum_a = sa; E_src_regnum_b = sb;
        M_en = men; M_kill = kill; A_en = aen; src1 = s1; src2 = s2;
        #1;
        hz  = E_mul_hazard;
        mhz = hit(mv, mdst, sa, sb) | hit(av, adst, sa, sb)
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
            | hit(pv, pdst, sa, sb)
`endif
            ;
        @(posedge clk);
        model_step(ev, edst, men, kill, aen, s1, s2);
        @(negedge clk);
    endtask

    typedef struct {
        logic        ev;
        logic [4:0]  edst, sa, sb;
        logic        men, kill, aen;
        logic [31:0] s1, s2;
        logic        x_hz, x_av;
        logic [31:0] x_res;
        logic [4:0]  x_dst;
        logic        chk_data;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic ev, input logic [4:0] edst, input logic [4:0] sa,
                                input logic [4:0] sb, input logic men, input logic kill,
                                input logic aen, input logic [31:0] s1, input logic [31:0] s2,
                                input logic x_hz, input logic x_av, input logic [31:0] x_res,
                                input logic [4:0] x_dst, input logic chk_data);
        vec_t v;
        v.ev = ev; v.edst = edst; v.sa = sa; v.sb = sb; v.men = men; v.kill = kill;
        v.aen = aen; v.s1 = s1; v.s2 = s2; v.x_hz = x_hz; v.x_av = x_av;
        v.x_res = x_res; v.x_dst = x_dst; v.chk_data = chk_data;
        return v;
    endfunction

    logic hz, mhz;
    int   lat;

    initial begin
        //             ev edst sa sb men kil aen s1            s2            hz av res           dst chk
        vt[0]  = mk(1, 3, 0, 0, 1, 0, 1, 32'h0001_0002, 32'h0003_0004, 0, 0, 32'h0,         0, 1);
        vt[1]  = mk(0, 0, 3, 0, 1, 0, 1, 32'h0,         32'h0,         1, 1, 32'h000A_0008, 3, 1);
        vt[2]  = mk(1, 4, 3, 3, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 1);
        vt[3]  = mk(0, 0, 4, 0, 1, 0, 1, 32'h0,         32'h0,         1, 1, 32'h1,         4, 1);
        vt[4]  = mk(1, 5, 0, 0, 1, 0, 0, 32'h1234,      32'h10,        0, 1, 32'h1,         4, 1);
        vt[5]  = mk(1, 6, 5, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h1,         4, 1);
        vt[6]  = mk(1, 6, 5, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h1,         4, 1);
        vt[7]  = mk(1, 6, 5, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h1,         4, 1);
        vt[8]  = mk(0, 0, 0, 0, 1, 0, 1, 32'h0,         32'h0,         0, 1, 32'h12340,     5, 1);
        vt[9]  = mk(1, 7, 0, 0, 1, 0, 1, 32'h3,         32'h5,         0, 0, 32'h0,         0, 1);
        vt[10] = mk(0, 0, 7, 0, 0, 1, 1, 32'h0,         32'h0,         1, 0, 32'hF,         7, 0);
        vt[11] = mk(1, 8, 7, 0, 1, 0, 1, 32'h1_0000,    32'h1_0001,    0, 0, 32'hF,         7, 1);
        vt[12] = mk(0, 0, 0, 8, 1, 0, 1, 32'h0,         32'h0,         1, 1, 32'h1_0000,    8, 1);
        vt[13] = mk(1, 9, 0, 0, 1, 0, 0, 32'h7,         32'h6,         0, 1, 32'h1_0000,    8, 1);
        vt[14] = mk(0, 0, 0, 9, 0, 0, 0, 32'h0,         32'h0,         1, 1, 32'h1_0000,    8, 1);
        vt[15] = mk(1, 0, 0, 9, 1, 0, 1, 32'h2,         32'h2,         1, 1, 32'd42,        9, 1);
        vt[16] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         0, 1, 32'd42,        9, 1);
        vt[17] = mk(0, 0, 0, 9, 0, 0, 1, 32'h0,         32'h0,         1, 0, 32'h0,         0, 1);
        vt[18] = mk(0, 0, 0, 9, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1);

        reset_n = 0; E_mul_valid = 0; E_dst_regnum = 0; E_src_regnum_a = 0; E_src_regnum_b = 0;
        M_en = 0; M_kill = 0; A_en = 0; src1 = 0; src2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'h0, A_mul_valid}, 32'h0);
        check("reset_result", A_mul_result, 32'h0);
        check("reset_dst", {27'h0, A_mul_dst_regnum}, 32'h0);
        check("reset_hazard", {31'h0, E_mul_hazard}, 32'h0);
        reset_n = 1;

`ifndef HW_QSYS_MUL_SPLIT_ADD_EN
        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].ev, vt[i].edst, vt[i].sa, vt[i].sb, vt[i].men, vt[i].kill,
                  vt[i].aen, vt[i].s1, vt[i].s2, hz, mhz);
            $display("vec %0d: hz=%0d av=%0d res=%h dst=%0d", i, hz, A_mul_valid,
                     A_mul_result, A_mul_dst_regnum);
            check($sformatf("tbl%0d_hazard", i), {31'h0, hz}, {31'h0, vt[i].x_hz});
            check($sformatf("tbl%0d_valid", i), {31'h0, A_mul_valid}, {31'h0, vt[i].x_av});
            if (vt[i].chk_data) begin
                check($sformatf("tbl%0d_result", i), A_mul_result, vt[i].x_res);
                check($sformatf("tbl%0d_dst", i), {27'h0, A_mul_dst_regnum}, {27'h0, vt[i].x_dst});
            end
        end
`endif

        // Mid-flight reset: fill M and A, then drop reset between clock edges.
        cycle(1, 3, 0, 0, 1, 0, 1, 32'h5, 32'h6, hz, mhz);
        cycle(1, 5, 0, 0, 1, 0, 1, 32'h7, 32'h8, hz, mhz);
        cycle(1, 6, 0, 0, 1, 0, 1, 32'h9, 32'h9, hz, mhz);
        E_src_regnum_a = 6; E_src_regnum_b = 5;
        #2;
        reset_n = 0;
        #1;
        $display("async reset: av=%0d res=%h dst=%0d hz=%0d", A_mul_valid, A_mul_result,
                 A_mul_dst_regnum, E_mul_hazard);
        check("arst_valid", {31'h0, A_mul_valid}, 32'h0);
        check("arst_result", A_mul_result, 32'h0);
        check("arst_dst", {27'h0, A_mul_dst_regnum}, 32'h0);
        check("arst_hazard", {31'h0, E_mul_hazard}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1;

        // Issue-to-result latency, including the extra stage when the add is split.
`ifdef HW_QSYS_MUL_SPLIT_ADD_EN
        lat = 3;
`else
        lat = 2;
`endif
        cycle(1, 2, 0, 0, 1, 0, 1, 32'h0001_0002, 32'h0003_0004, hz, mhz);
        for (int k = 1; k < lat; k++) begin
            check($sformatf("lat_edge%0d_valid", k), {31'h0, A_mul_valid}, 32'h0);
            cycle(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, hz, mhz);
        end
        $display("latency %0d: av=%0d res=%h", lat, A_mul_valid, A_mul_result);
        check("lat_valid", {31'h0, A_mul_valid}, 32'h1);
        check("lat_result", A_mul_result, 32'h000A_0008);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic        r_ev, r_men, r_kill, r_aen;
            logic [4:0]  r_dst, r_sa, r_sb;
            logic [31:0] r_s1, r_s2;
            r_ev   = 1'($urandom_range(0, 1));
            r_dst  = 5'($urandom_range(0, 7));
            r_sa   = 5'($urandom_range(0, 7));
            r_sb   = 5'($urandom_range(0, 7));
            r_men  = ($urandom_range(0, 3) != 0);
            r_kill = ($urandom_range(0, 7) == 0);
            r_aen  = ($urandom_range(0, 3) != 0);
            r_s1   = $urandom;
            r_s2   = $urandom;
            cycle(r_ev, r_dst, r_sa, r_sb, r_men, r_kill, r_aen, r_s1, r_s2, hz, mhz);
            $display("rnd %0d: hz=%0d av=%0d res=%h dst=%0d", n, hz, A_mul_valid,
                     A_mul_result, A_mul_dst_regnum);
            check($sformatf("rnd%0d_hazard", n), {31'h0, hz}, {31'h0, mhz});
            check($sformatf("rnd%0d_valid", n), {31'h0, A_mul_valid}, {31'h0, av});
            check($sformatf("rnd%0d_result", n), A_mul_result, ares);
            check($sformatf("rnd%0d_dst", n), {27'h0, A_mul_dst_regnum}, {27'h0, adst});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
